gshare_predictor: RTL and testbench
===================================

# gshare_predictor

- Parametrised gshare branch direction predictor for the RISC-V pipeline.
- Fetch: indexes a table of 2^IDX_W saturating counters with (PC ^ global history) and returns a taken/not-taken prediction in the same cycle.
- Execute: resolved branches and jumps update the counter at the index the pipeline carried from fetch, and shift the global history register (GHR).
- Adds over the previous 16-entry PHT:
  - configurable table depth, history length and counter width;
  - a reset/flush table-initialisation sweep;
  - same-cycle update bypass;
  - mispredict detection and saturating performance counters.

## Interface
- IDX_W, 6, table index width; table depth = 2^IDX_W
- HIST_W, 6, GHR length; legal range 1..IDX_W
- CTR_W, 2, counter width; legal range 1..4
- INIT_CTR, 2^(CTR_W-1), value written to every entry by the init sweep (weakly taken)
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_F  in  32  fetch PC
- predict_F  out  1  predicted direction = MSB of ctr_F
- ctr_F  out  CTR_W  counter value read at idx_F
- idx_F  out  IDX_W  hashed index; the pipeline carries it to E as idx_E
- branch_E  in  1  resolved conditional branch in E
- jump_E  in  1  resolved unconditional jump (JAL/JALR) in E
- take_E  in  1  actual branch outcome
- pred_E  in  1  predict_F value carried with this branch
- idx_E  in  IDX_W  index carried from fetch
- mispredict_E  out  1  branch_E & ready & (pred_E != take_E); combinational
- flush_tbl  in  1  synchronous re-initialisation request
- clr_stats  in  1  synchronous clear of the performance counters
- ready  out  1  1 = table valid, predictor in RUN
- cnt_branch  out  CNT_W  branches resolved while ready
- cnt_miss  out  CNT_W  mispredicted branches

## Operation
- **Hash:** idx_F = pc_F[IDX_W+1:2] ^ zero-extended GHR; GHR occupies the low HIST_W bits.
- **FSM states:** INIT and RUN.
- **Reset:**
  - FSM enters INIT with init_ptr=0; GHR=0.
  - cnt_branch = 0, cnt_miss = 0.
- **INIT:**
  - Each cycle writes INIT_CTR to entry init_ptr, then init_ptr+1.
  - After writing entry 2^IDX_W-1, moves to RUN on the next edge.
  - While in INIT: ready=0, predict_F=0, ctr_F=0, mispredict_E=0.
  - branch_E and jump_E are ignored in INIT: no table, GHR or counter change.
- **flush_tbl:**
  - Sampled on the edge, in any state: FSM goes to INIT, init_ptr=0, GHR=0.
  - flush_tbl has priority over any same-cycle update.
- **RUN, branch_E=1:**
  - entry[idx_E] saturates: +1 if take_E, capped at 2^CTR_W-1; -1 if not, floored at 0.
  - GHR <= {GHR[HIST_W-2:0], take_E}.
  - cnt_branch increments.
  - cnt_miss increments if mispredict_E.
  - Both counters hold at all-ones (saturate, no wrap).
- **RUN, jump_E=1 and branch_E=0:**
  - entry[idx_E] <= 2^CTR_W-1.
  - GHR shifts in 1.
  - Jumps are not counted in cnt_branch or cnt_miss.
- **branch_E and jump_E both high:** treated as a branch.
- **Bypass:**
  - Condition: RUN, a same-cycle update targets idx_E == idx_F.
  - ctr_F / predict_F show the post-update value.
  - idx_F always uses the pre-update GHR.
- **clr_stats:**
  - Zeroes both performance counters on the edge.
  - Overrides any same-cycle increment.
  - Does not affect the table or GHR.

## Timing
- **Reset values:**
  - ready=0, predict_F=0, ctr_F=0, mispredict_E=0, cnt_branch=0, cnt_miss=0.
  - idx_F = pc_F[IDX_W+1:2], since GHR=0.
- **Read path:** prediction is combinational from pc_F; zero-cycle latency.
- **Init duration:**
  - INIT lasts exactly 2^IDX_W cycles after reset deassertion or after the flush_tbl edge.
  - ready rises on edge 2^IDX_W + 1, counting the first post-reset edge as 1.
- **Update latency:** a table or GHR update is visible on the cycle after the E edge, except through the same-cycle bypass.
- **Async reset mid-sweep:** restarts the sweep from 0.
- **flush_tbl mid-sweep:** restarts the sweep from 0.
- **Index reach:** the hash never exceeds 2^IDX_W-1; there are no out-of-range entries.

## Test plan
- **Reset/init:**
  - Stimulus: IDX_W=4, release rst_n.
  - Required: ready=0 for 16 cycles, then 1; every entry reads INIT_CTR=2; predict_F=1.
- **Saturation and history:**
  - Stimulus: pc_F=0x40 with GHR 0, giving idx 0x0; then 3× branch_E, take_E=0, idx_E=0x0.
  - Required: entry 0 goes 2→1→0→0; GHR=0b000; predict_F=0 at pc 0x40.
- **Jump:**
  - Stimulus: jump_E, idx_E=5.
  - Required: entry 5 = 3; GHR LSB = 1; cnt_branch unchanged.
- **Bypass:**
  - Stimulus: idx_F == idx_E == 7, entry 7 = 1, branch_E taken in the same cycle.
  - Required: ctr_F=2 and predict_F=1 in that cycle.
- **Stats:**
  - Stimulus: 4 branches with pred_E/take_E = 1/1, 1/0, 0/0, 0/1; then clr_stats together with a fifth branch.
  - Required: cnt_branch=4 and cnt_miss=2; after the clr_stats edge, both read 0.
- **Flush and async reset:**
  - Stimulus: flush_tbl while in RUN, together with a branch_E.
  - Required: the update is dropped, ready=0, GHR=0, 2^IDX_W-cycle sweep.
  - Stimulus: assert rst_n low mid-sweep.
  - Required: outputs reach reset values immediately.

Source files
------------

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Gshare branch direction predictor. A table of 2^IDX_W saturating counters is
// indexed with (pc_F[IDX_W+1:2] ^ GHR) and read combinationally in fetch.
// Resolved branches/jumps in execute update the counter at the index carried
// from fetch and shift the global history register. After reset or flush_tbl
// the table is re-initialised by a one-entry-per-cycle sweep.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   pc_F           fetch PC
//   predict_F      predicted direction (MSB of ctr_F)
//   ctr_F          counter read at idx_F (post-update value on bypass)
//   idx_F          hashed table index, carried by the pipeline to idx_E
//   branch_E       resolved conditional branch
//   jump_E         resolved unconditional jump
//   take_E         actual outcome
//   pred_E         prediction carried with the branch
//   idx_E          index carried from fetch
//   mispredict_E   combinational mispredict flag
//   flush_tbl      synchronous table re-initialisation request
//   clr_stats      synchronous clear of the performance counters
//   ready          table valid, predictor in RUN
//   cnt_branch     saturating count of branches resolved while ready
//   cnt_miss       saturating count of mispredicted branches
// -----------------------------------------------------------------------------
module gshare_predictor #(
  parameter int IDX_W    = 6,
  parameter int HIST_W   = 6,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 2 ** (CTR_W - 1),
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_F,
  output logic             predict_F,
  output logic [CTR_W-1:0] ctr_F,
  output logic [IDX_W-1:0] idx_F,
  input  logic             branch_E,
  input  logic             jump_E,
  input  logic             take_E,
  input  logic             pred_E,
  input  logic [IDX_W-1:0] idx_E,
  output logic             mispredict_E,
  input  logic             flush_tbl,
  input  logic             clr_stats,
  output logic             ready,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_miss
);

  localparam int               DEPTH    = 1 << IDX_W;
  // The sweep pointer carries one extra bit: reaching DEPTH means "all
  // entries written", and the move to RUN happens on the following edge.
  localparam logic [IDX_W:0]   PTR_END  = {1'b1, {IDX_W{1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W:0]     init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0]  ghr_q;
  logic [CTR_W-1:0]   pht [DEPTH];

  logic               run;
  logic               upd_en;
  logic               bypass;
  logic               shift_bit;
  logic [CTR_W-1:0]   ctr_old;
  logic [CTR_W-1:0]   ctr_new;
  logic               unused_pc;

  // Only pc_F[IDX_W+1:2] participates in the hash.
  assign unused_pc = ^{pc_F[31:IDX_W+2], pc_F[1:0]};

  assign run          = (state_q == ST_RUN);
  assign ready        = run;
  assign idx_F        = pc_F[IDX_W+1:2] ^ IDX_W'(ghr_q);
  // flush_tbl wins over any same-cycle update, so it also suppresses bypass.
  assign upd_en       = run & (branch_E | jump_E) & ~flush_tbl;
  assign bypass       = upd_en & (idx_E == idx_F);
  assign shift_bit    = branch_E ? take_E : 1'b1;
  assign mispredict_E = branch_E & run & (pred_E ^ take_E);
  assign ctr_old      = pht[idx_E];

  // Next counter value: branches saturate up/down, jumps force strongly taken.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would infer a latch.
  always_comb begin
    ctr_new = CTR_MAX;
    if (branch_E) begin
      if (take_E) ctr_new = (ctr_old == CTR_MAX) ? ctr_old : ctr_old + CTR_W'(1);
      else        ctr_new = (ctr_old == '0)      ? ctr_old : ctr_old - CTR_W'(1);
    end
  end

  always_comb begin
    ctr_F = '0;
    if (run) ctr_F = bypass ? ctr_new : pht[idx_F];
  end

  assign predict_F = ctr_F[CTR_W-1];

  // FSM next state and sweep pointer.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (init_ptr_q == PTR_END) state_d = ST_RUN;
        else                       init_ptr_d = init_ptr_q + 1'b1;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
    if (flush_tbl) begin
      state_d    = ST_INIT;
      init_ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ghr_q <= '0;
    else if (flush_tbl) ghr_q <= '0;
    else if (upd_en)    ghr_q <= HIST_W'({ghr_q, shift_bit});
  end

  // NOTE: the counter table has no reset; the INIT sweep gives it defined
  // contents and predictions are masked to 0 until the sweep completes.
  always_ff @(posedge clk) begin
    if (!flush_tbl) begin
      if (state_q == ST_INIT && !init_ptr_q[IDX_W])
        pht[init_ptr_q[IDX_W-1:0]] <= CTR_INIT;
      else if (upd_en)
        pht[idx_E] <= ctr_new;
    end
  end

  // Performance counters saturate at all-ones; clr_stats overrides increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branch <= '0;
      cnt_miss   <= '0;
    end else if (clr_stats) begin
      cnt_branch <= '0;
      cnt_miss   <= '0;
    end else if (run && branch_E && !flush_tbl) begin
      if (cnt_branch != CNT_MAX)                 cnt_branch <= cnt_branch + 1'b1;
      if (mispredict_E && (cnt_miss != CNT_MAX)) cnt_miss   <= cnt_miss + 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
//
// Self-checking bench for gshare_predictor (IDX_W=4, HIST_W=3, CTR_W=2,
// CNT_W=4). A behavioural model tracks the table, history, sweep progress and
// statistics; each cycle the DUT outputs are compared with it, and directed
// steps cover init, saturation, jumps, bypass, stats, flush and async reset.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

  localparam int IDX_W    = 4;
  localparam int HIST_W   = 3;
  localparam int CTR_W    = 2;
  localparam int INIT_CTR = 2;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 16;
  localparam int CTR_TOP  = 3;
  localparam int CNT_TOP  = 15;
  localparam int HIST_MOD = 8;

  logic             clk;
  logic             rst_n;
  logic [31:0]      pc_F;
  logic             predict_F;
  logic [CTR_W-1:0] ctr_F;
  logic [IDX_W-1:0] idx_F;
  logic             branch_E;
  logic             jump_E;
  logic             take_E;
  logic             pred_E;
  logic [IDX_W-1:0] idx_E;
  logic             mispredict_E;
  logic             flush_tbl;
  logic             clr_stats;
  logic             ready;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_miss;

  gshare_predictor #(
    .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W),
    .INIT_CTR(INIT_CTR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .predict_F(predict_F),
    .ctr_F(ctr_F), .idx_F(idx_F), .branch_E(branch_E), .jump_E(jump_E),
    .take_E(take_E), .pred_E(pred_E), .idx_E(idx_E),
    .mispredict_E(mispredict_E), .flush_tbl(flush_tbl),
    .clr_stats(clr_stats), .ready(ready), .cnt_branch(cnt_branch),
    .cnt_miss(cnt_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int m_tbl [DEPTH];
  int m_ghr;
  bit m_ready;
  int m_init_edges;
  int m_cb;
  int m_cm;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int f_idx();
    return int'(pc_F[IDX_W+1:2]) ^ m_ghr;
  endfunction

  function automatic int f_newval(input int old);
    if (!branch_E) return CTR_TOP;
    if (take_E)    return (old + 1 > CTR_TOP) ? CTR_TOP : old + 1;
    return (old - 1 < 0) ? 0 : old - 1;
  endfunction

  function automatic int f_ctr();
    int i;
    int v;
    if (!m_ready) return 0;
    i = f_idx();
    v = m_tbl[i];
    if ((branch_E || jump_E) && !flush_tbl && int'(idx_E) == i) v = f_newval(v);
    return v;
  endfunction

  task automatic model_reset();
    m_ready      = 1'b0;
    m_init_edges = 0;
    m_ghr        = 0;
    m_cb         = 0;
    m_cm         = 0;
  endtask

  // Applies the effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (clr_stats) begin
      m_cb = 0;
      m_cm = 0;
    end else if (m_ready && branch_E && !flush_tbl) begin
      if (m_cb < CNT_TOP) m_cb++;
      if (pred_E != take_E && m_cm < CNT_TOP) m_cm++;
    end
    if (flush_tbl) begin
      m_ready      = 1'b0;
      m_init_edges = 0;
      m_ghr        = 0;
    end else if (!m_ready) begin
      m_init_edges++;
      if (m_init_edges <= DEPTH) m_tbl[m_init_edges-1] = INIT_CTR;
      else                       m_ready = 1'b1;
    end else if (branch_E || jump_E) begin
      m_tbl[int'(idx_E)] = f_newval(m_tbl[int'(idx_E)]);
      m_ghr = (m_ghr * 2 + ((branch_E) ? int'(take_E) : 1)) % HIST_MOD;
    end
  endtask

  // Called just after an edge with inputs already driven: checks all outputs
  // against the model, then advances one clock.
  task automatic step();
    int c;
    #2;
    c = f_ctr();
    check("ready",        32'(ready),        32'(m_ready));
    check("ctr_F",        32'(ctr_F),        c);
    check("predict_F",    32'(predict_F),    (c >= 2) ? 1 : 0);
    check("idx_F",        32'(idx_F),        f_idx());
    check("mispredict_E", 32'(mispredict_E), (m_ready && branch_E && pred_E != take_E) ? 1 : 0);
    check("cnt_branch",   32'(cnt_branch),   m_cb);
    check("cnt_miss",     32'(cnt_miss),     m_cm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    branch_E  = 1'b0;
    jump_E    = 1'b0;
    take_E    = 1'b0;
    pred_E    = 1'b0;
    idx_E     = '0;
    flush_tbl = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    int seq_exp [3];
    int cb_before;
    int guard;
    bit pat_pred [4];
    bit pat_take [4];

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    pc_F  = 32'h3C;
    branch_E = 1'b1;
    pred_E   = 1'b1;

    // Reset values.
    #12;
    check("rst_ready",   32'(ready),        0);
    check("rst_ctr",     32'(ctr_F),        0);
    check("rst_predict", 32'(predict_F),    0);
    check("rst_misp",    32'(mispredict_E), 0);
    check("rst_cnt_b",   32'(cnt_branch),   0);
    check("rst_cnt_m",   32'(cnt_miss),     0);
    check("rst_idx",     32'(idx_F),        32'hF);
    idle_inputs();
    rst_n = 1'b1;

    // Init sweep: ready low through edge 16, high after edge 17.
    repeat (16) step();
    check("init_ready_lo", 32'(ready), 0);
    step();
    check("init_ready_hi", 32'(ready), 1);

    // Every entry holds INIT_CTR.
    for (int i = 0; i < DEPTH; i++) begin
      pc_F = 32'(i) << 2;
      #1;
      check("init_entry", 32'(ctr_F), INIT_CTR);
      step();
    end

    // Saturation down at idx 0, observed through bypass: 2 -> 1 -> 0 -> 0.
    seq_exp = '{1, 0, 0};
    for (int j = 0; j < 3; j++) begin
      pc_F = 32'h40; branch_E = 1'b1; take_E = 1'b0; pred_E = 1'b1; idx_E = '0;
      #1;
      check("sat_bypass", 32'(ctr_F), seq_exp[j]);
      step();
    end
    idle_inputs();
    pc_F = 32'h40;
    #1;
    check("sat_predict", 32'(predict_F), 0);
    check("sat_ghr_idx", 32'(idx_F),     0);
    step();

    // Jump at idx 5.
    cb_before = m_cb;
    pc_F = 32'h3C; jump_E = 1'b1; idx_E = 4'd5;
    step();
    idle_inputs();
    pc_F = 32'h0;
    #1;
    check("jump_ghr", 32'(idx_F), 1);
    pc_F = 32'h10;
    #1;
    check("jump_entry", 32'(ctr_F),      3);
    check("jump_cnt",   32'(cnt_branch), cb_before);
    step();

    // Bring entry 7 to 1, then a taken branch on idx 7 with idx_F == 7.
    branch_E = 1'b1; take_E = 1'b0; idx_E = 4'd7; pc_F = 32'h0;
    step();
    pc_F = 32'((7 ^ m_ghr) << 2); branch_E = 1'b1; take_E = 1'b1; idx_E = 4'd7;
    #1;
    check("byp_idx",     32'(idx_F),     7);
    check("byp_ctr",     32'(ctr_F),     2);
    check("byp_predict", 32'(predict_F), 1);
    step();
    idle_inputs();

    // Stats.
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    pat_pred = '{1'b1, 1'b1, 1'b0, 1'b0};
    pat_take = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      branch_E = 1'b1; idx_E = 4'd9; pred_E = pat_pred[k]; take_E = pat_take[k];
      step();
    end
    idle_inputs();
    #1;
    check("stats_branch", 32'(cnt_branch), 4);
    check("stats_miss",   32'(cnt_miss),   2);
    branch_E = 1'b1; pred_E = 1'b1; take_E = 1'b0; idx_E = 4'd9; clr_stats = 1'b1;
    step();
    idle_inputs();
    #1;
    check("clr_branch", 32'(cnt_branch), 0);
    check("clr_miss",   32'(cnt_miss),   0);
    step();

    // Randomised traffic against the model.
    repeat (500) begin
      pc_F      = $urandom;
      branch_E  = 1'($urandom_range(0, 1));
      jump_E    = ($urandom_range(0, 3) == 0);
      take_E    = 1'($urandom_range(0, 1));
      pred_E    = 1'($urandom_range(0, 1));
      idx_E     = IDX_W'($urandom_range(0, DEPTH - 1));
      flush_tbl = ($urandom_range(0, 79) == 0);
      clr_stats = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();

    // Return to RUN, bounded by the sweep length.
    guard = 0;
    while (!m_ready && guard < 2 * DEPTH) begin
      step();
      guard++;
    end
    check("run_reached", 32'(ready), 1);

    // Flush together with a branch: update dropped, sweep restarts.
    cb_before = m_cb;
    pc_F = 32'h24; branch_E = 1'b1; take_E = 1'b1; pred_E = 1'b0; idx_E = 4'd3; flush_tbl = 1'b1;
    step();
    idle_inputs();
    #1;
    check("flush_ready", 32'(ready),      0);
    check("flush_ghr",   32'(idx_F),      9);
    check("flush_cnt",   32'(cnt_branch), cb_before);
    repeat (16) step();
    check("flush_ready_lo", 32'(ready), 0);
    step();
    check("flush_ready_hi", 32'(ready), 1);
    pc_F = 32'(3 << 2);
    #1;
    check("flush_entry", 32'(ctr_F), INIT_CTR);
    step();

    // Generate some stats, then flush mid-sweep and async reset mid-sweep.
    repeat (3) begin
      branch_E = 1'b1; pred_E = 1'b1; take_E = 1'b0; idx_E = 4'd2;
      step();
    end
    flush_tbl = 1'b1;
    step();
    idle_inputs();
    repeat (5) step();
    flush_tbl = 1'b1;
    step();
    flush_tbl = 1'b0;
    repeat (5) step();
    pc_F = 32'h2C; branch_E = 1'b1; pred_E = 1'b1; take_E = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready),        0);
    check("arst_ctr",   32'(ctr_F),        0);
    check("arst_pred",  32'(predict_F),    0);
    check("arst_misp",  32'(mispredict_E), 0);
    check("arst_cnt_b", 32'(cnt_branch),   0);
    check("arst_cnt_m", 32'(cnt_miss),     0);
    check("arst_idx",   32'(idx_F),        32'hB);
    model_reset();
    #3;
    rst_n = 1'b1;
    idle_inputs();
    repeat (16) step();
    check("arst_ready_lo", 32'(ready), 0);
    step();
    check("arst_ready_hi", 32'(ready), 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
